// File: rtl/board_grid_gen.sv
// board_grid_gen: registered pixel-to-cell decode and wrapping selection cursor for a COLS x ROWS board overlay.
// Optional macro SELRECT_BLINK_EN blinks selrect every BLINK_FRAMES frames, restarting on any cursor move.
module board_grid_gen #(
  parameter int COLS = 8,
  parameter int ROWS = 8,
  parameter int PITCH_X = 60,
  parameter int PITCH_Y = 60,
  parameter int X_OFF = 10,
  parameter int Y_OFF = 5,
  parameter int CELL_W = 50,
  parameter int CELL_H = 50,
  parameter int BLINK_FRAMES = 30,
  localparam int CW = $clog2(COLS),
  localparam int RW = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  input  logic          mv_up,
  input  logic          mv_dn,
  input  logic          mv_lf,
  input  logic          mv_rt,
  output logic          inrect,
  output logic          selrect,
  output logic [CW-1:0] cell_col,
  output logic [RW-1:0] cell_row,
  output logic [CW-1:0] pos_x,
  output logic [RW-1:0] pos_y
);
  if (COLS < 2 || COLS > 16 || ROWS < 2 || ROWS > 16 || BLINK_FRAMES < 1) begin : g_bad
    $error("board_grid_gen: parameter out of range");
  end
  int xi, yi;
  logic col_hit, row_hit, hit, sel_hit, show;
  logic [CW-1:0] col_idx, nxt_x;
  logic [RW-1:0] row_idx, nxt_y;
  assign xi = {22'd0, x};
  assign yi = {22'd0, y};
  // Scan from the top index down so the lowest matching index is the one left standing.
  always_comb begin
    col_hit = 1'b0;
    col_idx = '0;
    for (int i = COLS - 1; i >= 0; i--)
      if (xi > PITCH_X * i + X_OFF && xi < PITCH_X * i + X_OFF + CELL_W) begin
        col_hit = 1'b1;
        col_idx = CW'(i);
      end
  end
  always_comb begin
    row_hit = 1'b0;
    row_idx = '0;
    for (int j = ROWS - 1; j >= 0; j--)
      if (yi > PITCH_Y * j + Y_OFF && yi < PITCH_Y * j + Y_OFF + CELL_H) begin
        row_hit = 1'b1;
        row_idx = RW'(j);
      end
  end
  assign hit = col_hit && row_hit;
  assign sel_hit = hit && col_idx == pos_x && row_idx == pos_y;
  always_comb begin
    nxt_x = (mv_rt && !mv_lf) ? (pos_x == CW'(COLS - 1) ? '0 : pos_x + 1'b1)
          : (mv_lf && !mv_rt) ? (pos_x == '0 ? CW'(COLS - 1) : pos_x - 1'b1)
          : pos_x;
    nxt_y = (mv_dn && !mv_up) ? (pos_y == RW'(ROWS - 1) ? '0 : pos_y + 1'b1)
          : (mv_up && !mv_dn) ? (pos_y == '0 ? RW'(ROWS - 1) : pos_y - 1'b1)
          : pos_y;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pos_x <= '0;
      pos_y <= '0;
    end else begin
      pos_x <= nxt_x;
      pos_y <= nxt_y;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      inrect   <= 1'b0;
      selrect  <= 1'b0;
      cell_col <= '0;
      cell_row <= '0;
    end else if (pix_en) begin
      inrect   <= hit;
      selrect  <= sel_hit && show;
      cell_col <= hit ? col_idx : '0;
      cell_row <= hit ? row_idx : '0;
    end
`ifdef SELRECT_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [BW-1:0] frm_cnt;
  logic phase, frame_start, any_mv;
  assign frame_start = pix_en && x == '0 && y == '0;
  assign any_mv = mv_up || mv_dn || mv_lf || mv_rt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      frm_cnt <= '0;
      phase   <= 1'b1;
    end else if (any_mv) begin
      frm_cnt <= '0;
      phase   <= 1'b1;
    end else if (frame_start) begin
      frm_cnt <= frm_cnt == BW'(BLINK_FRAMES - 1) ? '0 : frm_cnt + 1'b1;
      phase   <= frm_cnt == BW'(BLINK_FRAMES - 1) ? ~phase : phase;
    end
  assign show = phase;
`else
  assign show = 1'b1;
`endif
endmodule

// File: tb/tb_board_grid_gen.sv
// tb_board_grid_gen: directed checks of cell decode, cursor wrap, hold, async reset and optional blink.
module tb_board_grid_gen;
  logic clk = 1'b0;
  logic rst_n;
  logic pix_en;
  logic [9:0] x, y;
  logic mv_up, mv_dn, mv_lf, mv_rt, mv5_lf, mv5_rt;
  logic inrect, selrect;
  logic [2:0] cell_col, cell_row, pos_x, pos_y;
  logic in5, sel5;
  logic [2:0] col5, pos5_x;
  logic [2:0] row5, pos5_y;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  board_grid_gen #(.BLINK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x(x), .y(y),
    .mv_up(mv_up), .mv_dn(mv_dn), .mv_lf(mv_lf), .mv_rt(mv_rt),
    .inrect(inrect), .selrect(selrect), .cell_col(cell_col), .cell_row(cell_row),
    .pos_x(pos_x), .pos_y(pos_y)
  );

  board_grid_gen #(.COLS(5), .ROWS(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .pix_en(1'b0), .x(x), .y(y),
    .mv_up(1'b0), .mv_dn(1'b0), .mv_lf(mv5_lf), .mv_rt(mv5_rt),
    .inrect(in5), .selrect(sel5), .cell_col(col5), .cell_row(row5),
    .pos_x(pos5_x), .pos_y(pos5_y)
  );

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    pix_en = 0; mv_up = 0; mv_dn = 0; mv_lf = 0; mv_rt = 0; mv5_lf = 0; mv5_rt = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    cyc();
    rst_n = 1;
    cyc();
  endtask

  task automatic test_reset();
    idle();
    x = 10'd11; y = 10'd6;
    rst_n = 0;
    pix_en = 1;
    cyc();
    cyc();
    n_checks++;
    if ({inrect, selrect, cell_col, cell_row, pos_x, pos_y} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset: got in=%b sel=%b col=%0d row=%0d pos=(%0d,%0d), want all 0",
               inrect, selrect, cell_col, cell_row, pos_x, pos_y);
    end
    pix_en = 0;
    rst_n = 1;
    cyc();
  endtask

  task automatic test_first_pixel();
    x = 10'd11; y = 10'd6; pix_en = 1;
    cyc();
    pix_en = 0;
    n_checks++;
    if ({inrect, selrect, cell_col, cell_row} !== {1'b1, 1'b1, 3'd0, 3'd0}) begin
      n_fail++;
      $display("FAIL first_pixel: got in=%b sel=%b col=%0d row=%0d, want 1 1 0 0",
               inrect, selrect, cell_col, cell_row);
    end
  endtask

  task automatic test_boundaries();
    logic [9:0] vx [8] = '{10'd10, 10'd60, 10'd59, 10'd71, 10'd119, 10'd120, 10'd11, 10'd11};
    logic [9:0] vy [8] = '{10'd30, 10'd30, 10'd30, 10'd30, 10'd30, 10'd30, 10'd55, 10'd66};
    logic [6:0] ve [8] = '{7'b0_000_000, 7'b0_000_000, 7'b1_000_000, 7'b1_001_000,
                           7'b1_001_000, 7'b0_000_000, 7'b0_000_000, 7'b1_000_001};
    for (int i = 0; i < 8; i++) begin
      x = vx[i]; y = vy[i]; pix_en = 1;
      cyc();
      n_checks++;
      if ({inrect, cell_col, cell_row} !== ve[i]) begin
        n_fail++;
        $display("FAIL boundary x=%0d y=%0d: got in=%b col=%0d row=%0d, want in=%b col=%0d row=%0d",
                 vx[i], vy[i], inrect, cell_col, cell_row, ve[i][6], ve[i][5:3], ve[i][2:0]);
      end
    end
    pix_en = 0;
  endtask

  task automatic test_cursor_wrap();
    do_reset();
    mv_lf = 1;
    cyc();
    mv_lf = 0;
    n_checks++;
    if (pos_x !== 3'd7) begin n_fail++; $display("FAIL wrap_left: got pos_x=%0d, want 7", pos_x); end
    mv_up = 1;
    cyc();
    mv_up = 0;
    n_checks++;
    if (pos_y !== 3'd7) begin n_fail++; $display("FAIL wrap_up: got pos_y=%0d, want 7", pos_y); end
    x = 10'd450; y = 10'd440; pix_en = 1;
    cyc();
    pix_en = 0;
    n_checks++;
    if ({inrect, selrect, cell_col, cell_row} !== {1'b1, 1'b1, 3'd7, 3'd7}) begin
      n_fail++;
      $display("FAIL corner_cell: got in=%b sel=%b col=%0d row=%0d, want 1 1 7 7",
               inrect, selrect, cell_col, cell_row);
    end
    mv_rt = 1; mv_dn = 1;
    cyc();
    mv_rt = 0; mv_dn = 0;
    n_checks++;
    if ({pos_x, pos_y} !== 6'd0) begin
      n_fail++; $display("FAIL wrap_right_down: got pos=(%0d,%0d), want (0,0)", pos_x, pos_y);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      mv_rt = 1; mv_dn = 1;
      cyc();
    end
    mv_rt = 0; mv_dn = 0;
    n_checks++;
    if ({pos_x, pos_y} !== {3'd3, 3'd3}) begin
      n_fail++; $display("FAIL diag_moves: got pos=(%0d,%0d), want (3,3)", pos_x, pos_y);
    end
    mv_lf = 1; mv_rt = 1; mv_dn = 1;
    cyc();
    mv_lf = 0; mv_rt = 0; mv_dn = 0;
    n_checks++;
    if ({pos_x, pos_y} !== {3'd3, 3'd4}) begin
      n_fail++; $display("FAIL lf_rt_dn: got pos=(%0d,%0d), want (3,4)", pos_x, pos_y);
    end
    mv_up = 1; mv_dn = 1; mv_rt = 1;
    cyc();
    mv_up = 0; mv_dn = 0; mv_rt = 0;
    n_checks++;
    if ({pos_x, pos_y} !== {3'd4, 3'd4}) begin
      n_fail++; $display("FAIL up_dn_rt: got pos=(%0d,%0d), want (4,4)", pos_x, pos_y);
    end
    x = 10'd260; y = 10'd260; pix_en = 1;
    cyc();
    n_checks++;
    if ({inrect, selrect, cell_col, cell_row} !== {1'b1, 1'b1, 3'd4, 3'd4}) begin
      n_fail++;
      $display("FAIL sel_cell44: got in=%b sel=%b col=%0d row=%0d, want 1 1 4 4",
               inrect, selrect, cell_col, cell_row);
    end
    y = 10'd200;
    cyc();
    pix_en = 0;
    n_checks++;
    if ({inrect, selrect, cell_col, cell_row} !== {1'b1, 1'b0, 3'd4, 3'd3}) begin
      n_fail++;
      $display("FAIL nonsel_cell43: got in=%b sel=%b col=%0d row=%0d, want 1 0 4 3",
               inrect, selrect, cell_col, cell_row);
    end
  endtask

  task automatic test_nonpow2();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mv5_rt = 1;
      cyc();
    end
    mv5_rt = 0;
    n_checks++;
    if (pos5_x !== 3'd4) begin n_fail++; $display("FAIL cols5_four: got pos_x=%0d, want 4", pos5_x); end
    mv5_rt = 1;
    cyc();
    mv5_rt = 0;
    n_checks++;
    if (pos5_x !== 3'd0) begin n_fail++; $display("FAIL cols5_wrap: got pos_x=%0d, want 0", pos5_x); end
    mv5_lf = 1;
    cyc();
    mv5_lf = 0;
    n_checks++;
    if (pos5_x !== 3'd4) begin n_fail++; $display("FAIL cols5_left: got pos_x=%0d, want 4", pos5_x); end
  endtask

  task automatic test_same_cycle_move();
    do_reset();
    x = 10'd11; y = 10'd6; pix_en = 1; mv_rt = 1;
    cyc();
    mv_rt = 0;
    n_checks++;
    if ({selrect, pos_x} !== {1'b1, 3'd1}) begin
      n_fail++; $display("FAIL old_cursor_sel: got sel=%b pos_x=%0d, want 1 1", selrect, pos_x);
    end
    cyc();
    pix_en = 0;
    n_checks++;
    if ({inrect, selrect} !== 2'b10) begin
      n_fail++; $display("FAIL moved_away: got in=%b sel=%b, want 1 0", inrect, selrect);
    end
  endtask

  task automatic test_hold();
    do_reset();
    x = 10'd71; y = 10'd30; pix_en = 1;
    cyc();
    pix_en = 0;
    x = 10'd11; y = 10'd6;
    cyc();
    x = 10'd450; y = 10'd440;
    cyc();
    n_checks++;
    if ({inrect, selrect, cell_col, cell_row} !== {1'b1, 1'b0, 3'd1, 3'd0}) begin
      n_fail++;
      $display("FAIL hold: got in=%b sel=%b col=%0d row=%0d, want 1 0 1 0",
               inrect, selrect, cell_col, cell_row);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    mv_rt = 1; mv_dn = 1;
    cyc();
    mv_rt = 0; mv_dn = 0;
    x = 10'd71; y = 10'd66; pix_en = 1;
    cyc();
    pix_en = 0;
    #2 rst_n = 0;
    #1;
    n_checks++;
    if ({inrect, selrect, cell_col, cell_row, pos_x, pos_y} !== 14'd0) begin
      n_fail++;
      $display("FAIL async_reset: got in=%b sel=%b col=%0d row=%0d pos=(%0d,%0d), want all 0",
               inrect, selrect, cell_col, cell_row, pos_x, pos_y);
    end
    @(negedge clk);
    rst_n = 1;
    x = 10'd11; y = 10'd6; pix_en = 1;
    #1;
    n_checks++;
    if (inrect !== 1'b0) begin n_fail++; $display("FAIL pre_edge: got in=%b, want 0", inrect); end
    @(negedge clk);
    pix_en = 0;
    n_checks++;
    if ({inrect, selrect} !== 2'b11) begin
      n_fail++; $display("FAIL post_release: got in=%b sel=%b, want 1 1", inrect, selrect);
    end
  endtask

`ifdef SELRECT_BLINK_EN
  task automatic test_blink();
    do_reset();
    x = 10'd0; y = 10'd0; pix_en = 1;
    cyc();
    cyc();
    x = 10'd11; y = 10'd6;
    cyc();
    pix_en = 0;
    n_checks++;
    if ({inrect, selrect} !== 2'b10) begin
      n_fail++; $display("FAIL blink_off: got in=%b sel=%b, want 1 0", inrect, selrect);
    end
    mv_rt = 1;
    cyc();
    mv_rt = 0;
    x = 10'd71; y = 10'd6; pix_en = 1;
    cyc();
    pix_en = 0;
    n_checks++;
    if ({inrect, selrect, cell_col} !== {1'b1, 1'b1, 3'd1}) begin
      n_fail++;
      $display("FAIL blink_move_on: got in=%b sel=%b col=%0d, want 1 1 1", inrect, selrect, cell_col);
    end
  endtask
`endif

  initial begin
    x = 10'd0; y = 10'd0;
    test_reset();
    test_first_pixel();
    test_boundaries();
    test_cursor_wrap();
    test_conflict();
    test_nonpow2();
    test_same_cycle_move();
    test_hold();
    test_async_reset();
`ifdef SELRECT_BLINK_EN
    test_blink();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
